psa_pipe: RTL
=============

Name: psa_pipe

Overview:
Parametrised, pipelined packed saturating adder/subtractor. It operates on LANES independent signed lanes of LANE_W bits each. It supports add or subtract, each with saturate or wrap behaviour, and reports per-lane overflow. It sits in the execute datapath behind a valid/ready handshake and keeps sticky overflow flags plus a saturating event counter for status readout.

Parameters:
LANE_W, 4, bits per signed lane (>=2)
LANES, 4, number of lanes; packed width DW = LANES*LANE_W
CNT_W, 8, width of saturation-event counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_a  input  DW  packed operand A, lane i = bits [i*LANE_W +: LANE_W]
in_b  input  DW  packed operand B
in_op  input  2  00 add-sat, 01 sub-sat, 10 add-wrap, 11 sub-wrap
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
out_sum  output  DW  packed result
out_sat  output  LANES  per-lane signed overflow of this result
clr_status  input  1  synchronous clear of sat_sticky and sat_count
sat_sticky  output  LANES  OR of out_sat over accepted results since last clear
sat_count  output  CNT_W  number of accepted results with any out_sat bit set

Behaviour:
- Reset (async, immediate): out_valid=0, internal stage valids=0, out_sum=0, out_sat=0, sat_sticky=0, sat_count=0. in_ready=1 once reset is released. In-flight beats are discarded.
- Pipeline:
  - S1 registers in_a, in_b, in_op.
  - S2 registers the computed out_sum and out_sat.
  - Latency is 2 cycles from the input handshake to out_valid, with full throughput (one beat per cycle) when out_ready=1.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from out_ready. No other combinational in-to-out path.
  - A beat transfers when valid && ready. Data is held stable while out_valid && !out_ready.
  - No loss, no duplication, order preserved.
  - in_valid may drop without a handshake.
- Per-lane arithmetic:
  - Sub computes a + ~b + 1.
  - Overflow = operand signs (after inverting b for sub) equal and raw-result sign differs.
  - Sat modes on overflow: raw sign 1 (positive overflow) -> 0 followed by ones (max positive); raw sign 0 -> 1 followed by zeros (min negative).
  - Wrap modes: raw LANE_W-bit result.
  - out_sat is set on overflow in all four modes.
  - There are no carries between lanes.
- Status (updated only on output handshake out_valid && out_ready):
  - sat_sticky |= out_sat.
  - sat_count increments by 1 if |out_sat and holds at all-ones (no wrap).
- clr_status in the same cycle as a counted handshake: clear is applied first, then the event. Result is sticky = out_sat of that beat, count = 1.

Decomposition:
- Package psa_pkg: psa_op_e enum (OP_ADD_SAT, OP_SUB_SAT, OP_ADD_WRAP, OP_SUB_WRAP), helper functions sat_max/sat_min(LANE_W).
- Sub-module psa_lane: combinational single-lane add/sub with overflow detect and saturate (ports a, b, op, sum, ovfl). Instantiated LANES times via generate in S2's input logic.

Test Plan:
- Defaults, op=00, A=16'h781F, B=16'h1F21 -> out_sum=16'h7830, out_sat=4'b1100, out_valid 2 cycles after handshake.
- Same operands, op=10 -> out_sum=16'h8730, out_sat=4'b1100. Then A=16'h8000, B=16'h1000: op=01 -> 16'h8000, sat=4'b1000; op=11 -> 16'h7000, sat=4'b1000.
- out_ready=0 for 6 cycles while driving 3 back-to-back beats:
  - in_ready drops after 2 beats are accepted.
  - On release, all 3 results appear in order, once each, then 1 beat/cycle streaming with no bubbles.
- rst asserted mid-cycle with both stages full -> out_valid, sat_sticky, sat_count go 0 without a clock edge. After release, the first new beat appears 2 cycles after its handshake.
- CNT_W=2, 5 accepted saturating results -> sat_count=3 (held). clr_status -> 0. A non-overflow result does not increment.
- clr_status coincident with an accepted beat having out_sat=4'b0010, previous sticky=4'b1001 -> sat_sticky=4'b0010, sat_count=1.

Source files
------------

// File: rtl/psa_pkg.sv
// Shared types and helpers for the packed saturating add/sub pipeline.
// Operation encoding matches the 2-bit in_op input directly.
package psa_pkg;

    typedef enum logic [1:0] {
        OP_ADD_SAT  = 2'b00,
        OP_SUB_SAT  = 2'b01,
        OP_ADD_WRAP = 2'b10,
        OP_SUB_WRAP = 2'b11
    } psa_op_e;

    // Largest positive value of a w-bit two's-complement lane: 0 followed by ones.
    function automatic logic [31:0] sat_max(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Most negative value of a w-bit two's-complement lane: 1 followed by zeros.
    function automatic logic [31:0] sat_min(input int w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic op_is_sub(input psa_op_e op);
        return (op == OP_SUB_SAT) || (op == OP_SUB_WRAP);
    endfunction

    function automatic logic op_is_sat(input psa_op_e op);
        return (op == OP_ADD_SAT) || (op == OP_SUB_SAT);
    endfunction

endpackage

// File: rtl/psa_lane.sv
// One signed lane: add or subtract, signed-overflow detect, optional saturation.
// Purely combinational; the enclosing pipeline registers the result.
module psa_lane
    import psa_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  psa_op_e      op,
    output logic [W-1:0] sum,
    output logic         ovfl
);

    localparam logic [W-1:0] MAX_V = W'(sat_max(W));
    localparam logic [W-1:0] MIN_V = W'(sat_min(W));

    logic         is_sub;
    logic         is_sat;
    logic [W-1:0] b_eff;
    logic [W-1:0] raw;

    always_comb begin
        is_sub = op_is_sub(op);
        is_sat = op_is_sat(op);
        // Subtraction is a + ~b + 1, so overflow is judged on the inverted b.
        b_eff  = is_sub ? ~b : b;
        raw    = a + b_eff + {{(W-1){1'b0}}, is_sub};
        ovfl   = (a[W-1] == b_eff[W-1]) && (raw[W-1] != a[W-1]);

        sum = raw;
        if (is_sat && ovfl) begin
            sum = raw[W-1] ? MAX_V : MIN_V;
        end
    end

endmodule

// File: rtl/psa_pipe.sv
// Two-stage packed saturating adder/subtractor behind valid/ready, with
// sticky per-lane overflow flags and a saturating overflow-event counter.
module psa_pipe
    import psa_pkg::*;
#(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   in_a,
    input  logic [LANES*LANE_W-1:0]   in_b,
    input  logic [1:0]                in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   out_sum,
    output logic [LANES-1:0]          out_sat,
    input  logic                      clr_status,
    output logic [LANES-1:0]          sat_sticky,
    output logic [CNT_W-1:0]          sat_count
);

    localparam int DW = LANES * LANE_W;

    // Handshake: a beat moves when valid && ready on that boundary. A stage
    // advances when it is empty or its consumer takes its beat this cycle;
    // in_ready is the only combinational path (from out_ready).

    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_a_q, s1_a_d;
    logic [DW-1:0] s1_b_q, s1_b_d;
    psa_op_e       s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [DW-1:0]    s2_sum_q, s2_sum_d;
    logic [LANES-1:0] s2_sat_q, s2_sat_d;

    logic [LANES-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             s1_adv;
    logic             s2_adv;
    logic             out_hs;
    logic [DW-1:0]    lane_sum;
    logic [LANES-1:0] lane_ovf;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = s2_valid_q && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        psa_lane #(
            .W (LANE_W)
        ) u_lane (
            .a    (s1_a_q[i*LANE_W +: LANE_W]),
            .b    (s1_b_q[i*LANE_W +: LANE_W]),
            .op   (s1_op_q),
            .sum  (lane_sum[i*LANE_W +: LANE_W]),
            .ovfl (lane_ovf[i])
        );
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d  = in_a;
                s1_b_d  = in_b;
                s1_op_d = psa_op_e'(in_op);
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_sat_d   = s2_sat_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d = lane_sum;
                s2_sat_d = lane_ovf;
            end
        end
    end

    // Clear lands before a same-cycle event so that event is still recorded.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clr_status) begin
            sticky_d = '0;
            count_d  = '0;
        end
        if (out_hs) begin
            sticky_d = sticky_d | s2_sat_q;
            if ((|s2_sat_q) && (count_d != {CNT_W{1'b1}})) begin
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_ADD_SAT;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_sat_q   <= '0;
            sticky_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_sat_q   <= s2_sat_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_sum    = s2_sum_q;
    assign out_sat    = s2_sat_q;
    assign sat_sticky = sticky_q;
    assign sat_count  = count_q;

endmodule
